// File: rtl/baccarat_fsm.sv
// baccarat_fsm -- control FSM for the Baccarat table.
//
// Sequences the six card-load strobes for the card datapath, one card per
// slow_clock edge. It applies the third-card rules to the scores read back
// from the datapath, decides the winner and latches the win lights.
//
// Ports:
//   slow_clock        game clock; all state changes happen on its rising edge
//   resetb            asynchronous active-low reset
//   pscore, dscore    player / dealer hand score 0..9 (combinational from datapath)
//   pcard3            player third card raw code (0=none, 1=A, 2..10, 11..13=J/Q/K)
//   load_pcard1..3    load strobes for player cards 1..3 (Moore, from state)
//   load_dcard1..3    load strobes for dealer cards 1..3 (Moore, from state)
//   player_win_light  player wins (both lights on = tie)
//   dealer_win_light  dealer wins
//   done              hand complete; outputs frozen until reset
module baccarat_fsm (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done
);

  typedef enum logic [3:0] {
    S_P1     = 4'd0,
    S_D1     = 4'd1,
    S_P2     = 4'd2,
    S_D2     = 4'd3,
    S_EVAL   = 4'd4,
    S_P3     = 4'd5,
    S_BDEC   = 4'd6,
    S_D3     = 4'd7,
    S_RESULT = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  state_t     state;
  logic [3:0] third_val;
  logic       dealer_draws;

  // Face cards and tens count zero toward the banker's decision.
  always_comb begin
    third_val = (pcard3 <= 4'd9) ? pcard3 : '0;
  end

  // Banker's third-card rule, keyed on the dealer's two-card score.
  always_comb begin
    dealer_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
      4'd3:             dealer_draws = (third_val != 4'd8);
      4'd4:             dealer_draws = (third_val >= 4'd2) && (third_val <= 4'd7);
      4'd5:             dealer_draws = (third_val >= 4'd4) && (third_val <= 4'd7);
      4'd6:             dealer_draws = (third_val >= 4'd6) && (third_val <= 4'd7);
      default:          dealer_draws = 1'b0;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state            <= S_P1;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      done             <= 1'b0;
    end else begin
      case (state)
        S_P1: state <= S_D1;
        S_D1: state <= S_P2;
        S_P2: state <= S_D2;
        S_D2: state <= S_EVAL;
        S_EVAL: begin
          if ((pscore >= 4'd8) || (dscore >= 4'd8)) state <= S_RESULT;
          else if (pscore <= 4'd5)                  state <= S_P3;
          else if (dscore <= 4'd5)                  state <= S_D3;
          else                                      state <= S_RESULT;
        end
        S_P3:   state <= S_BDEC;
        S_BDEC: state <= dealer_draws ? S_D3 : S_RESULT;
        S_D3:   state <= S_RESULT;
        S_RESULT: begin
          // A tie sets both lights, so each light is a non-strict compare.
          player_win_light <= (pscore >= dscore);
          dealer_win_light <= (dscore >= pscore);
          done             <= 1'b1;
          state            <= S_DONE;
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_P1;
      endcase
    end
  end

  always_comb begin
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    case (state)
      S_P1:    load_pcard1 = 1'b1;
      S_D1:    load_dcard1 = 1'b1;
      S_P2:    load_pcard2 = 1'b1;
      S_D2:    load_dcard2 = 1'b1;
      S_P3:    load_pcard3 = 1'b1;
      S_D3:    load_dcard3 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_baccarat_fsm.sv
// tb_baccarat_fsm -- directed, table-driven bench for baccarat_fsm.
// Each record describes one hand: the two-card scores, the player's third
// card, the final scores after any draws, and the expected draws, lights
// and edge count at which done rises.
module tb_baccarat_fsm;

  logic       slow_clock;
  logic       resetb;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, done;

  int unsigned n_pass;
  int unsigned n_total;

  baccarat_fsm dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .done             (done)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  typedef struct {
    logic [3:0] ps;     // player two-card score
    logic [3:0] ds;     // dealer two-card score
    logic [3:0] pc3;    // player third card code
    logic [3:0] ps2;    // player score after third card
    logic [3:0] ds2;    // dealer score after third card
    bit         p3;     // expect load_pcard3
    bit         d3;     // expect load_dcard3
    bit         pw;
    bit         dw;
    int         edges;  // edge after which done/lights are valid
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] ps, ds, pc3, ps2, ds2,
                              input bit p3, d3, pw, dw, input int edges);
    vec_t v;
    v.ps = ps; v.ds = ds; v.pc3 = pc3; v.ps2 = ps2; v.ds2 = ds2;
    v.p3 = p3; v.d3 = d3; v.pw = pw; v.dw = dw; v.edges = edges;
    return v;
  endfunction

  // Banker rule as a per-score mask of third-card values (bit v set = draws).
  function automatic bit bank_ref(input logic [3:0] ds, input logic [3:0] code);
    logic [9:0] mask;
    int unsigned val;
    val = (code >= 4'd10) ? 0 : int'(code);
    case (ds)
      4'd0, 4'd1, 4'd2: mask = 10'h3FF;
      4'd3:             mask = 10'h2FF;
      4'd4:             mask = 10'h0FC;
      4'd5:             mask = 10'h0F0;
      4'd6:             mask = 10'h0C0;
      default:          mask = 10'h000;
    endcase
    return mask[val];
  endfunction

  function automatic logic [8:0] outs();
    return {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3,
            load_dcard3, player_win_light, dealer_win_light, done};
  endfunction

  task automatic run_hand(input vec_t v, input string name);
    logic [5:0] strobes;
    logic [5:0] prefix[4];
    bit   p3, d3, order_err, multi, early;
    int   edges, done_edge;
    logic [2:0] held;
    prefix[0] = 6'b100000; prefix[1] = 6'b010000;
    prefix[2] = 6'b001000; prefix[3] = 6'b000100;
    p3 = 0; d3 = 0; order_err = 0; multi = 0; early = 0;
    edges = 0; done_edge = -1;
    resetb = 1'b0;
    pscore = v.ps; dscore = v.ds; pcard3 = v.pc3;
    #3;
    chk({name, " reset outs"}, 32'(outs()), 32'h100);
    @(negedge slow_clock);
    resetb = 1'b1;
    while (edges < 14) begin
      strobes = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
      if (done) begin
        done_edge = edges;
        break;
      end
      if ($countones(strobes) > 1) multi = 1;
      if (edges < 4 && strobes != prefix[edges]) order_err = 1;
      if (edges >= 4 && strobes[5:2] != 4'b0) order_err = 1;
      if (player_win_light || dealer_win_light) early = 1;
      if (strobes[1]) p3 = 1;
      if (strobes[0]) d3 = 1;
      @(posedge slow_clock);
      edges++;
      #1;
      // The datapath score reflects a newly loaded card from the next cycle.
      if (strobes[1]) pscore = v.ps2;
      if (strobes[0]) dscore = v.ds2;
      @(negedge slow_clock);
    end
    chk({name, " strobe order"}, 32'(order_err), 32'd0);
    chk({name, " one strobe"},   32'(multi),     32'd0);
    chk({name, " early light"},  32'(early),     32'd0);
    chk({name, " pcard3 drawn"}, 32'(p3),        32'(v.p3));
    chk({name, " dcard3 drawn"}, 32'(d3),        32'(v.d3));
    chk({name, " done edge"},    32'(done_edge), 32'(v.edges));
    chk({name, " player light"}, 32'(player_win_light), 32'(v.pw));
    chk({name, " dealer light"}, 32'(dealer_win_light), 32'(v.dw));
    // Scores wander after the hand; outputs must stay frozen.
    held = {player_win_light, dealer_win_light, done};
    pscore = 4'd0; dscore = 4'd9;
    repeat (2) @(negedge slow_clock);
    chk({name, " frozen"}, 32'(outs()), 32'({6'b0, held}));
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    resetb = 1'b0; pscore = '0; dscore = '0; pcard3 = '0;

    //            ps    ds    pc3    ps2   ds2   p3 d3 pw dw edges
    vecs[0]  = mk(4'd8, 4'd3, 4'd0,  4'd8, 4'd3, 0, 0, 1, 0, 6); // player natural
    vecs[1]  = mk(4'd4, 4'd5, 4'd13, 4'd4, 4'd5, 1, 0, 0, 1, 8); // K counts 0, dealer 5 stands
    vecs[2]  = mk(4'd6, 4'd5, 4'd0,  4'd6, 4'd6, 0, 1, 1, 1, 7); // dealer draws only, tie
    vecs[3]  = mk(4'd7, 4'd6, 4'd0,  4'd7, 4'd6, 0, 0, 1, 0, 6); // both stand
    vecs[4]  = mk(4'd3, 4'd2, 4'd9,  4'd1, 4'd7, 1, 1, 0, 1, 9); // both draw
    vecs[5]  = mk(4'd2, 4'd9, 4'd0,  4'd2, 4'd9, 0, 0, 0, 1, 6); // dealer natural
    vecs[6]  = mk(4'd5, 4'd6, 4'd6,  4'd1, 4'd0, 1, 1, 1, 0, 9); // dealer 6 draws on 6
    vecs[7]  = mk(4'd8, 4'd8, 4'd0,  4'd8, 4'd8, 0, 0, 1, 1, 6); // natural tie
    vecs[8]  = mk(4'd0, 4'd7, 4'd10, 4'd0, 4'd7, 1, 0, 0, 1, 8); // dealer 7 never draws
    vecs[9]  = mk(4'd2, 4'd3, 4'd8,  4'd2, 4'd3, 1, 0, 0, 1, 8); // dealer 3 stands on 8
    vecs[10] = mk(4'd2, 4'd6, 4'd7,  4'd2, 4'd6, 1, 1, 0, 1, 9); // dealer 6 draws on 7

    for (int i = 0; i < 11; i++) run_hand(vecs[i], $sformatf("vec%0d", i));

    // Banker rule sweep with the player on 2.
    for (int ds = 0; ds < 8; ds++) begin
      for (int c = 1; c < 14; c++) begin
        vec_t v;
        bit   draw;
        draw = bank_ref(4'(ds), 4'(c));
        v = mk(4'd2, 4'(ds), 4'(c), 4'd2, 4'(ds), 1, draw,
               (ds <= 2), (ds >= 2), draw ? 9 : 8);
        run_hand(v, $sformatf("sweep d%0d c%0d", ds, c));
      end
    end

    // Async reset while in S_BDEC.
    resetb = 1'b0; pscore = 4'd4; dscore = 4'd5; pcard3 = 4'd13;
    @(negedge slow_clock);
    resetb = 1'b1;
    repeat (6) @(posedge slow_clock);
    @(negedge slow_clock);
    chk("bdec no strobe", 32'(outs()), 32'h000);
    #2 resetb = 1'b0;
    #1 chk("bdec async reset", 32'(outs()), 32'h100);
    run_hand(vecs[0], "after bdec reset");

    // Async reset while in S_DONE with both lights on.
    run_hand(vecs[2], "tie before reset");
    chk("done lights set", 32'(outs()), 32'h007);
    #2 resetb = 1'b0;
    #1 chk("done async reset", 32'(outs()), 32'h100);
    run_hand(vecs[4], "after done reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/baccarat_fsm.md
Name: baccarat_fsm

Overview:
Control FSM for the Baccarat table. It drives the six card-load strobes consumed by the card datapath and reads back the player score, dealer score and player third card. It applies the Baccarat third-card rules, decides the winner and latches the win lights. It runs on the same slow_clock as the card registers: one card per slow_clock edge.

Parameters:
None.

Ports:
slow_clock  input  1  game clock (pushbutton-driven); all state changes on rising edge
resetb  input  1  asynchronous active-low reset
pscore  input  4  player hand score 0..9, combinational from datapath
dscore  input  4  dealer hand score 0..9, combinational from datapath
pcard3  input  4  player third card raw code: 0=none, 1=A, 2..10, 11=J, 12=Q, 13=K
load_pcard1  output  1  load strobe, player card 1
load_pcard2  output  1  load strobe, player card 2
load_pcard3  output  1  load strobe, player card 3
load_dcard1  output  1  load strobe, dealer card 1
load_dcard2  output  1  load strobe, dealer card 2
load_dcard3  output  1  load strobe, dealer card 3
player_win_light  output  1  player wins (both lights on = tie)
dealer_win_light  output  1  dealer wins
done  output  1  hand complete, outputs frozen

Behaviour:
- Clocking and reset:
  - One clock, slow_clock. Reset is asynchronous and active-low on resetb.
  - resetb low forces state S_P1 and clears both lights and done to 0, immediately and independent of the clock.
  - Reset mid-hand aborts the hand and returns to S_P1 with no stale lights.
- Load strobes:
  - Moore outputs decoded from state only. At most one strobe is high in any state.
  - The datapath captures the card on the same rising edge that leaves the state.
  - Score inputs reflect a card from the first cycle after its load state.
- States, listed as state: strobe asserted -> next state:
  - S_P1: load_pcard1 -> S_D1
  - S_D1: load_dcard1 -> S_P2
  - S_P2: load_pcard2 -> S_D2
  - S_D2: load_dcard2 -> S_EVAL
  - S_EVAL: no strobe. Priority order:
    - pscore>=8 or dscore>=8 (natural) -> S_RESULT
    - else pscore<=5 -> S_P3
    - else dscore<=5 -> S_D3
    - else -> S_RESULT
  - S_P3: load_pcard3 -> S_BDEC
  - S_BDEC: no strobe. Compute v = pcard3 if pcard3<=9, else 0 (10/J/Q/K count 0). Dealer draws when:
    - dscore 0..2: always
    - dscore 3: v!=8
    - dscore 4: v in 2..7
    - dscore 5: v in 4..7
    - dscore 6: v in 6..7
    - dscore 7: never
    - Draw -> S_D3, else -> S_RESULT.
  - S_D3: load_dcard3 -> S_RESULT
  - S_RESULT: no strobe. On exit edge, register the lights:
    - pscore>dscore: player_win_light=1
    - dscore>pscore: dealer_win_light=1
    - equal: both lights = 1
    - Next -> S_DONE.
  - S_DONE: no strobe; done=1; lights held; stays in S_DONE until resetb.
- Latency from the first rising edge after reset release:
  - Natural or both stand: lights valid after edge 6.
  - Player draws, dealer stands: lights valid after edge 8.
  - Dealer draws only: lights valid after edge 7.
  - Both draw: lights valid after edge 9.
- Comparisons are unsigned 4-bit. Score inputs above 9 are undefined and need no checking.
- Lights and done change only on entry to S_DONE or on reset.
- All unused or illegal state encodings go to S_P1 on the next edge.

Test Plan:
- Reset then 4 edges -> exactly one strobe per cycle, in order load_pcard1, load_dcard1, load_pcard2, load_dcard2; all lights 0.
- Natural win: after S_D2, drive pscore=8, dscore=3 -> no pcard3/dcard3 strobe; after edge 6, player_win_light=1, dealer_win_light=0, done=1.
- Player draws, dealer conditional: pscore=4, dscore=5, pcard3=13 (v=0) -> load_pcard3 asserted, load_dcard3 never asserted. Then drive pscore=4 -> dealer_win_light=1 after edge 8.
- Banker rule sweep: pscore=2, and for each dscore 0..7 and pcard3 1..13, check load_dcard3 against the draw rules above. Example: dscore=6, pcard3=7 -> draws; dscore=3, pcard3=8 -> stands.
- Player stands, dealer draws: pscore=6, dscore=5 -> load_dcard3 only. Then dscore=6 -> tie, both lights=1, after edge 7.
- Async reset in S_BDEC and in S_DONE -> state S_P1 and lights 0 before the next edge; load_pcard1 asserted at once; next hand replays correctly.
